instr_encoder: RTL

- Encodes symbolic micro-op requests (mnemonic code plus register, immediate and target fields) into 32-bit MIPS instruction words.
- Emits words through a buffered valid/ready stream, each tagged with its sequential instruction address.
- Sits in the program-load path ahead of instruction memory, producing exactly the opcode/funct encodings the control unit decodes.

---
 rtl/instr_encoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic micro-op requests into 32-bit MIPS words and
// streams them out through a small FIFO. Each word carries its instruction
// address. The address starts at BASE_ADDR and advances by 4 for every legal word.
//
// Optional build macro: INSTR_ENCODER_BRANCH_ABS_EN
//   When it is defined, BEQ/BNE take in_imm as an absolute word address.
//   The encoder converts it to a PC-relative offset. An offset that does not
//   fit in 16 bits sets err_illegal, and the word is still pushed.
//   When it is not defined, in_imm is copied unchanged into every I-type word.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   clear                synchronous flush: FIFO, address counter and error
//   in_valid/in_ready    request handshake
//   in_op                mnemonic code (0..15 legal, 16..31 illegal)
//   in_rs/in_rt/in_rd    register fields
//   in_imm, in_target    immediate / branch operand, jump target
//   out_valid/out_ready  output handshake for the FIFO head
//   out_instr, out_addr  encoded word at the head and its address
//   err_illegal          sticky error flag
//   fill                 FIFO occupancy
module instr_encoder #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    in_op,
  input  logic [4:0]                    in_rs,
  input  logic [4:0]                    in_rt,
  input  logic [4:0]                    in_rd,
  input  logic [15:0]                   in_imm,
  input  logic [25:0]                   in_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          err_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [31:0] encode(input logic [4:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    case (op)
      5'd0:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      5'd1:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      5'd2:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      5'd3:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      5'd4:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100110};
      5'd5:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      5'd6:  w = {6'b001000, rs, rt, imm};
      5'd7:  w = {6'b001100, rs, rt, imm};
      5'd8:  w = {6'b001101, rs, rt, imm};
      5'd9:  w = {6'b001110, rs, rt, imm};
      5'd10: w = {6'b001010, rs, rt, imm};
      5'd11: w = {6'b000100, rs, rt, imm};
      5'd12: w = {6'b000101, rs, rt, imm};
      5'd13: w = {6'b100011, rs, rt, imm};
      5'd14: w = {6'b101011, rs, rt, imm};
      5'd15: w = {6'b000010, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_p0, rd_ptr_p0;
  logic [CW-1:0]     fill_p0, fill_n;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              err_p0;

  logic        full, accept, legal, push, pop;
  logic [15:0] imm_eff;
  logic        br_oor;
  logic [31:0] word;

  assign full   = (fill_p0 == CW'(FIFO_DEPTH));
  // Reset is folded in so that no request is accepted while rst_n is low.
  assign in_ready = rst_n & ~full & ~clear;
  assign accept   = in_valid & in_ready;
  assign legal    = ~in_op[4];
  assign push     = accept & legal;
  assign pop      = vld_p0 & out_ready;

`ifdef INSTR_ENCODER_BRANCH_ABS_EN
  // The offset is relative to the address of the following word, in word units.
  // The extra headroom bits hold the exact difference so the range check is exact.
  localparam int OW = ((ADDR_W > 16) ? ADDR_W : 16) + 2;
  logic [ADDR_W-1:0]    next_addr;
  logic signed [OW-1:0] br_off;
  logic                 is_branch;
  assign next_addr = addr_p0 + ADDR_W'(4);
  assign br_off    = $signed(OW'(in_imm)) - $signed(OW'(next_addr >> 2));
  assign is_branch = (in_op == 5'd11) || (in_op == 5'd12);
  assign imm_eff   = is_branch ? br_off[15:0] : in_imm;
  assign br_oor    = is_branch &&
                     ((br_off > $signed(OW'(32767))) || (br_off < -$signed(OW'(32768))));
`else
  assign imm_eff = in_imm;
  assign br_oor  = 1'b0;
`endif

  assign word   = encode(in_op, in_rs, in_rt, in_rd, imm_eff, in_target);
  assign fill_n = fill_p0 + CW'(push) - CW'(pop);

  // Stage p0: FIFO control, address counter and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      fill_p0   <= '0;
      vld_p0    <= 1'b0;
      addr_p0   <= BASE_ADDR;
      err_p0    <= 1'b0;
    end else if (clear) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      fill_p0   <= '0;
      vld_p0    <= 1'b0;
      addr_p0   <= BASE_ADDR;
      err_p0    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_p0 <= wr_ptr_p0 + PW'(1);
        addr_p0   <= addr_p0 + ADDR_W'(4);
      end
      if (pop)
        rd_ptr_p0 <= rd_ptr_p0 + PW'(1);
      fill_p0 <= fill_n;
      vld_p0  <= (fill_n != '0);
      if ((accept && !legal) || (push && br_oor))
        err_p0 <= 1'b1;
    end
  end

  // Stage p0: FIFO storage, written only on a push
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_p0] <= word;
      addr_mem[wr_ptr_p0]  <= addr_p0;
    end
  end

  // While the FIFO is empty the outputs are forced to zero, so stale storage is never seen.
  assign out_valid   = vld_p0;
  assign out_instr   = vld_p0 ? instr_mem[rd_ptr_p0] : '0;
  assign out_addr    = vld_p0 ? addr_mem[rd_ptr_p0]  : '0;
  assign err_illegal = err_p0;
  assign fill        = fill_p0;

endmodule
